gray_stream_checker: RTL and testbench
======================================

Name: gray_stream_checker

Overview:
- Consumes the 4-bit Gray-code stream produced by the binary-to-Gray stage and decodes each sample back to binary, registered.
- Checks that consecutive samples differ by exactly one count (up, down or hold) and reports the step direction.
- Counts step errors and raises a lock indication after a run of good steps.
- Sits directly downstream of the binary-to-Gray converter as the link-integrity monitor.

Parameters:
WIDTH, 4, Gray/binary word width (>=2)
ERR_CNT_W, 8, width of saturating error counter
LOCK_N, 4, consecutive good up/down steps required to assert locked (1..255)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
gray_valid  input  1  gray_in is valid this cycle
gray_in  input  WIDTH  Gray-code sample
resync  input  1  discard history; next valid sample becomes the new reference
clear_err  input  1  synchronous clear of err_count
bin_valid  output  1  one-cycle pulse; outputs below valid for this sample
bin_out  output  WIDTH  decoded binary of the last accepted sample
step_up  output  1  sample = previous+1 mod 2^WIDTH
step_down  output  1  sample = previous-1 mod 2^WIDTH
step_hold  output  1  sample = previous
step_err  output  1  any other difference
err_count  output  ERR_CNT_W  saturating count of step_err events
locked  output  1  LOCK_N good steps seen since last error/resync/reset

Behaviour:
- One clock; reset is synchronous and active-high (rst sampled on rising clk). All outputs, prev register, run counter and state return to 0/EMPTY. Reset has priority over every other input, including mid-stream.
- Decode: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] for i=WIDTH-2..0.
- Latency: gray_valid high in cycle n -> bin_valid, bin_out and step flags registered, visible in cycle n+1.
- gray_valid low: bin_valid and all step flags 0 next cycle. bin_out, prev, run, locked and err_count hold.
- States:
  - EMPTY: no reference sample. A valid sample loads prev, drives bin_out, pulses bin_valid with all step flags 0, and moves to TRACK.
  - TRACK: each valid sample is compared against prev. Exactly one flag pulses, priority up > down > hold > err. prev is then updated to the new sample, including on error.
- Wrap-around: prev=2^WIDTH-1 with new=0 is step_up; prev=0 with new=2^WIDTH-1 is step_down.
- Run counter (saturating at LOCK_N):
  - step_up/step_down: +1.
  - step_hold: unchanged.
  - step_err: cleared to 0.
  - locked is registered and updates in the same cycle as the flags: 1 when the updated run equals LOCK_N, 0 on step_err.
- err_count:
  - +1 per step_err, saturating at 2^ERR_CNT_W-1.
  - clear_err alone -> 0.
  - clear_err together with a step_err in the same update -> 1.
  - clear_err does not affect locked or run.
- resync (no gray_valid): state->EMPTY, run=0, locked=0; bin_out and err_count hold.
- resync together with gray_valid: that sample is treated as an EMPTY first sample (loaded, bin_valid=1, no flags, state TRACK).
- gray_in is ignored when gray_valid=0; X on gray_in then must not propagate.

Test Plan:
- Reset, then valid Gray 0000,0001,0011,0010,0110 on consecutive cycles:
  - bin_out 0,1,2,3,4 each one cycle later.
  - First sample has no flags; next four give step_up.
  - locked=1 with the 5th bin_valid; err_count=0.
- Wrap: Gray 1000 (15) then 0000 -> step_up. Then 1000 -> step_down. Then 1000 -> step_hold. err_count stays 0.
- Error: locked stream at 0001 (1), then 0010 (3) -> step_err, err_count=1, locked=0. Then 0110 (4) -> step_up, locked still 0 (run=1).
- Saturation (ERR_CNT_W=2): five alternating 0000/0101 error samples -> err_count 1,2,3,3,3. Then clear_err in the same cycle as an error -> err_count=1; clear_err alone -> 0.
- Resync and gaps:
  - Locked stream at 0010 (3); resync with gray_valid=0 -> locked=0.
  - Next sample 1100 (8): bin_valid=1, no flags, err_count unchanged.
  - gray_valid low for 3 cycles between samples: no bin_valid pulses, bin_out holds 8.
- Reset mid-stream: assert rst in the cycle a valid 0011 is presented -> next cycle all outputs 0, sample discarded. The following sample 0001 is treated as a first sample (no flags).

Source files
------------

// File: rtl/gray_stream_checker_if.sv
// gray_stream_checker_if: Gray sample input and decoded/step-status output bundle.
interface gray_stream_checker_if #(
  parameter int WIDTH = 4,
  parameter int ERR_CNT_W = 8
);
  logic gray_valid;
  logic [WIDTH-1:0] gray_in;
  logic resync;
  logic clear_err;
  logic bin_valid;
  logic [WIDTH-1:0] bin_out;
  logic step_up;
  logic step_down;
  logic step_hold;
  logic step_err;
  logic [ERR_CNT_W-1:0] err_count;
  logic locked;
  modport master (
    output gray_valid, gray_in, resync, clear_err,
    input bin_valid, bin_out, step_up, step_down, step_hold, step_err, err_count, locked
  );
  modport slave (
    input gray_valid, gray_in, resync, clear_err,
    output bin_valid, bin_out, step_up, step_down, step_hold, step_err, err_count, locked
  );
endinterface

// File: rtl/gray_stream_checker.sv
// gray_stream_checker: decodes a Gray stream and checks each sample is a single-count step.
module gray_stream_checker #(
  parameter int WIDTH = 4,
  parameter int ERR_CNT_W = 8,
  parameter int LOCK_N = 4
) (
  input logic clk,
  input logic rst,
  gray_stream_checker_if.slave bus
);
  localparam int RW = $clog2(LOCK_N + 1);
  localparam logic [RW-1:0] LOCK = RW'(LOCK_N);
  typedef enum logic {EMPTY, TRACK} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] prev, prev_n, dec, prev_inc, prev_dec, bin_n;
  logic [RW-1:0] run, run_n;
  logic [ERR_CNT_W-1:0] err_n;
  logic first, trk, up, dn, hd, er, locked_n;
  always_comb begin
    dec = '0;
    dec[WIDTH-1] = bus.gray_in[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) dec[i] = dec[i+1] ^ bus.gray_in[i];
  end
  // Flags are gated by gray_valid so an undriven gray_in never reaches state.
  always_comb begin
    prev_inc = prev + 1'b1;
    prev_dec = prev - 1'b1;
    first = bus.gray_valid && (bus.resync || state == EMPTY);
    trk = bus.gray_valid && !first;
    up = trk && dec == prev_inc;
    dn = trk && !up && dec == prev_dec;
    hd = trk && !up && !dn && dec == prev;
    er = trk && !up && !dn && !hd;
    state_n = bus.gray_valid ? TRACK : bus.resync ? EMPTY : state;
    prev_n = bus.gray_valid ? dec : prev;
    bin_n = bus.gray_valid ? dec : bus.bin_out;
    run_n = (first || bus.resync || er) ? '0 :
            (up || dn) ? ((run == LOCK) ? run : run + 1'b1) : run;
    locked_n = (bus.resync || er) ? 1'b0 : (up || dn) ? (run_n == LOCK) : bus.locked;
    err_n = bus.clear_err ? ERR_CNT_W'(er) :
            (er && bus.err_count != {ERR_CNT_W{1'b1}}) ? bus.err_count + 1'b1 : bus.err_count;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      prev <= '0;
      run <= '0;
      bus.bin_valid <= 1'b0;
      bus.bin_out <= '0;
      bus.step_up <= 1'b0;
      bus.step_down <= 1'b0;
      bus.step_hold <= 1'b0;
      bus.step_err <= 1'b0;
      bus.err_count <= '0;
      bus.locked <= 1'b0;
    end else begin
      state <= state_n;
      prev <= prev_n;
      run <= run_n;
      bus.bin_valid <= bus.gray_valid;
      bus.bin_out <= bin_n;
      bus.step_up <= up;
      bus.step_down <= dn;
      bus.step_hold <= hd;
      bus.step_err <= er;
      bus.err_count <= err_n;
      bus.locked <= locked_n;
    end
  end
endmodule

// File: tb/tb_gray_stream_checker.sv
// tb_gray_stream_checker: directed-vector bench; main instance plus a 2-bit error counter instance.
module tb_gray_stream_checker;
  logic clk = 0;
  logic rst;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  gray_stream_checker_if #(.WIDTH(4), .ERR_CNT_W(8)) m ();
  gray_stream_checker_if #(.WIDTH(4), .ERR_CNT_W(2)) s ();
  gray_stream_checker #(.WIDTH(4), .ERR_CNT_W(8), .LOCK_N(4)) dut (.clk(clk), .rst(rst), .bus(m.slave));
  gray_stream_checker #(.WIDTH(4), .ERR_CNT_W(2), .LOCK_N(4)) dut2 (.clk(clk), .rst(rst), .bus(s.slave));
  // {bin_valid, bin_out, up, down, hold, err, locked}
  logic [9:0] obs, obs2;
  assign obs = {m.bin_valid, m.bin_out, m.step_up, m.step_down, m.step_hold, m.step_err, m.locked};
  assign obs2 = {s.bin_valid, s.bin_out, s.step_up, s.step_down, s.step_hold, s.step_err, s.locked};
  task automatic drive(input logic v, input logic [3:0] g, input logic rs, input logic ce, input logic r);
    m.gray_valid = v;
    m.gray_in = g;
    m.resync = rs;
    m.clear_err = ce;
    rst = r;
    @(posedge clk);
    #1;
    m.gray_valid = 0;
    m.gray_in = 'x;
    m.resync = 0;
    m.clear_err = 0;
    rst = 0;
  endtask
  task automatic drive2(input logic v, input logic [3:0] g, input logic ce);
    s.gray_valid = v;
    s.gray_in = g;
    s.clear_err = ce;
    @(posedge clk);
    #1;
    s.gray_valid = 0;
    s.clear_err = 0;
  endtask
  task automatic test_reset();
    drive(0, 4'b0, 0, 0, 1);
    drive(0, 4'b0, 0, 0, 1);
    n_checks++;
    if (obs !== 10'b0) begin n_fail++; $display("FAIL reset_obs got %b want %b", obs, 10'b0); end
    n_checks++;
    if (m.err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err got %0d want 0", m.err_count); end
  endtask
  task automatic test_count();
    logic [3:0] g [5];
    logic [9:0] e [5];
    g = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
    e = '{{1'b1, 4'd0, 4'b0000, 1'b0}, {1'b1, 4'd1, 4'b1000, 1'b0}, {1'b1, 4'd2, 4'b1000, 1'b0},
          {1'b1, 4'd3, 4'b1000, 1'b0}, {1'b1, 4'd4, 4'b1000, 1'b1}};
    for (int k = 0; k < 5; k++) begin
      drive(1, g[k], 0, 0, 0);
      n_checks++;
      if (obs !== e[k]) begin n_fail++; $display("FAIL count[%0d] got %b want %b", k, obs, e[k]); end
    end
    n_checks++;
    if (m.err_count !== 8'd0) begin n_fail++; $display("FAIL count_err got %0d want 0", m.err_count); end
  endtask
  task automatic test_wrap();
    logic [3:0] g [4];
    logic [9:0] e [4];
    g = '{4'b1000, 4'b0000, 4'b1000, 4'b1000};
    e = '{{1'b1, 4'd15, 4'b0000, 1'b0}, {1'b1, 4'd0, 4'b1000, 1'b0},
          {1'b1, 4'd15, 4'b0100, 1'b0}, {1'b1, 4'd15, 4'b0010, 1'b0}};
    for (int k = 0; k < 4; k++) begin
      drive(1, g[k], k == 0, 0, 0);
      n_checks++;
      if (obs !== e[k]) begin n_fail++; $display("FAIL wrap[%0d] got %b want %b", k, obs, e[k]); end
    end
    n_checks++;
    if (m.err_count !== 8'd0) begin n_fail++; $display("FAIL wrap_err got %0d want 0", m.err_count); end
  endtask
  task automatic test_error();
    logic [3:0] g [7];
    logic [9:0] e [7];
    g = '{4'b1011, 4'b1001, 4'b1000, 4'b0000, 4'b0001, 4'b0010, 4'b0110};
    e = '{{1'b1, 4'd13, 4'b0000, 1'b0}, {1'b1, 4'd14, 4'b1000, 1'b0}, {1'b1, 4'd15, 4'b1000, 1'b0},
          {1'b1, 4'd0, 4'b1000, 1'b0}, {1'b1, 4'd1, 4'b1000, 1'b1}, {1'b1, 4'd3, 4'b0001, 1'b0},
          {1'b1, 4'd4, 4'b1000, 1'b0}};
    for (int k = 0; k < 7; k++) begin
      drive(1, g[k], k == 0, 0, 0);
      n_checks++;
      if (obs !== e[k]) begin n_fail++; $display("FAIL error[%0d] got %b want %b", k, obs, e[k]); end
      if (k == 5) begin
        n_checks++;
        if (m.err_count !== 8'd1) begin n_fail++; $display("FAIL error_cnt got %0d want 1", m.err_count); end
      end
    end
  endtask
  task automatic test_saturation();
    logic [1:0] e [5];
    e = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    drive2(1, 4'b0000, 0);
    n_checks++;
    if (obs2 !== {1'b1, 4'd0, 4'b0000, 1'b0}) begin n_fail++; $display("FAIL sat_first got %b", obs2); end
    for (int k = 0; k < 5; k++) begin
      drive2(1, (k % 2 == 0) ? 4'b0101 : 4'b0000, 0);
      n_checks++;
      if (s.err_count !== e[k] || s.step_err !== 1'b1) begin
        n_fail++;
        $display("FAIL sat[%0d] got cnt=%0d err=%b want cnt=%0d err=1", k, s.err_count, s.step_err, e[k]);
      end
    end
    drive2(1, 4'b0000, 1);
    n_checks++;
    if (s.err_count !== 2'd1) begin n_fail++; $display("FAIL sat_clear_err got %0d want 1", s.err_count); end
    drive2(0, 4'b0000, 1);
    n_checks++;
    if (s.err_count !== 2'd0) begin n_fail++; $display("FAIL sat_clear got %0d want 0", s.err_count); end
  endtask
  task automatic test_resync_gap();
    logic [3:0] g [5];
    g = '{4'b1000, 4'b0000, 4'b0001, 4'b0011, 4'b0010};
    for (int k = 0; k < 5; k++) drive(1, g[k], k == 0, 0, 0);
    n_checks++;
    if (obs !== {1'b1, 4'd3, 4'b1000, 1'b1}) begin n_fail++; $display("FAIL resync_lock got %b", obs); end
    drive(0, 4'bxxxx, 1, 0, 0);
    n_checks++;
    if (obs !== {1'b0, 4'd3, 4'b0000, 1'b0}) begin n_fail++; $display("FAIL resync_drop got %b", obs); end
    drive(1, 4'b1100, 0, 0, 0);
    n_checks++;
    if (obs !== {1'b1, 4'd8, 4'b0000, 1'b0}) begin n_fail++; $display("FAIL resync_first got %b", obs); end
    n_checks++;
    if (m.err_count !== 8'd1) begin n_fail++; $display("FAIL resync_err got %0d want 1", m.err_count); end
    for (int k = 0; k < 3; k++) begin
      drive(0, 4'bxxxx, 0, 0, 0);
      n_checks++;
      if (obs !== {1'b0, 4'd8, 4'b0000, 1'b0}) begin n_fail++; $display("FAIL gap[%0d] got %b", k, obs); end
    end
    drive(1, 4'b1101, 0, 0, 0);
    n_checks++;
    if (obs !== {1'b1, 4'd9, 4'b1000, 1'b0}) begin n_fail++; $display("FAIL gap_after got %b", obs); end
  endtask
  task automatic test_mid_reset();
    drive(1, 4'b0011, 0, 0, 1);
    n_checks++;
    if (obs !== 10'b0 || m.err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset got %b cnt=%0d want 0", obs, m.err_count);
    end
    drive(1, 4'b0001, 0, 0, 0);
    n_checks++;
    if (obs !== {1'b1, 4'd1, 4'b0000, 1'b0}) begin n_fail++; $display("FAIL post_reset got %b", obs); end
  endtask
  initial begin
    m.gray_valid = 0; m.gray_in = 0; m.resync = 0; m.clear_err = 0;
    s.gray_valid = 0; s.gray_in = 0; s.resync = 0; s.clear_err = 0;
    rst = 1;
    test_reset();
    test_count();
    test_wrap();
    test_error();
    test_saturation();
    test_resync_gap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
